// File: rtl/fighter_pkg.sv
// Shared fighter definitions: player action encodings, screen geometry,
// sprite overlay row offsets and the per-fighter motion FSM states.
package fighter_pkg;

  localparam int unsigned SCREEN_W_PX = 640;
  localparam int unsigned SCREEN_H_PX = 480;

  // Row offsets inside the body rectangle
  localparam int unsigned BANDANA_TOP = 10;
  localparam int unsigned BANDANA_BOT = 20;
  localparam int unsigned HITBOX_TOP  = 32;
  localparam int unsigned HITBOX_BOT  = 48;

  typedef enum logic [3:0] {
    S_IDLE            = 4'd0,
    S_Forward         = 4'd1,
    S_Backward        = 4'd2,
    S_Crouch          = 4'd3,
    S_Jump            = 4'd4,
    S_Attack_startup  = 4'd5,
    S_Attack_active   = 4'd6,
    S_Attack_recovery = 4'd7,
    S_DirAtk_active   = 4'd8,
    S_Hitstun         = 4'd9,
    S_Blockstun       = 4'd10
  } fighter_state_e;

  typedef enum logic [1:0] {
    M_HOLD  = 2'd0,
    M_WALK  = 2'd1,
    M_KNOCK = 2'd2
  } motion_e;

  function automatic logic is_walk(input logic [3:0] s);
    return (s == S_Forward) || (s == S_Backward);
  endfunction

endpackage

// File: rtl/fighter_sprite_motion_if.sv
// Bundle between the player FSM / pixel path (master) and one fighter's
// motion and overlay engine (slave).
interface fighter_sprite_motion_if;
  logic       frame_tick;
  logic [3:0] state;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic       in_body;
  logic       in_bandana;
  logic       in_hitbox;
  logic       knockback;

  modport master (
    output frame_tick, state, pixel_x, pixel_y,
    input  sprite_x, sprite_y, in_body, in_bandana, in_hitbox, knockback
  );

  modport slave (
    input  frame_tick, state, pixel_x, pixel_y,
    output sprite_x, sprite_y, in_body, in_bandana, in_hitbox, knockback
  );
endinterface

// File: rtl/sprite_rect_hit.sv
// Registered half-open rectangle test: hit <= en && x0<=px<x1 && y0<=py<y1,
// with bounds widened to 11 bits so edges past the screen never wrap.
module sprite_rect_hit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  input  logic [10:0] x0,
  input  logic [10:0] x1,
  input  logic [10:0] y0,
  input  logic [10:0] y1,
  output logic        hit
);
  logic [10:0] pxe;
  logic [10:0] pye;

  assign pxe = {1'b0, px};
  assign pye = {1'b0, py};

  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= 1'b0;
    end else begin
      hit <= en && (pxe >= x0) && (pxe < x1) && (pye >= y0) && (pye < y1);
    end
  end
endmodule

// File: rtl/fighter_sprite_motion.sv
// Per-fighter motion (walk / knockback, clamped to screen) and registered
// body / bandana / hitbox region flags. Hitbox only with FIGHTER_HITBOX_EN.
module fighter_sprite_motion
  import fighter_pkg::*;
#(
  parameter int unsigned IS_MIRRORED = 0,
  parameter int unsigned SCREEN_W    = SCREEN_W_PX,
  parameter int unsigned SPRITE_W    = 64,
  parameter int unsigned SPRITE_H    = 128,
  parameter int unsigned START_X     = 100,
  parameter int unsigned Y_POS       = 100,
  parameter int unsigned MARGIN      = 2,
  parameter int unsigned FWD_STEP    = 3,
  parameter int unsigned BACK_STEP   = 2,
  parameter int unsigned KB_STEP     = 4,
  parameter int unsigned KB_FRAMES   = 8,
  parameter int unsigned HIT_W       = 40
) (
  input logic clk,
  input logic rst,
  fighter_sprite_motion_if.slave bus
);

  localparam bit MIR = (IS_MIRRORED != 0);
  // Signed per-tick deltas; forward is -x for the mirrored player
  localparam int FWD_D  = MIR ? -int'(FWD_STEP)  : int'(FWD_STEP);
  localparam int BACK_D = MIR ?  int'(BACK_STEP) : -int'(BACK_STEP);
  localparam int KB_D   = MIR ?  int'(KB_STEP)   : -int'(KB_STEP);

  localparam logic signed [10:0] X_LO = 11'(MARGIN);
  localparam logic signed [10:0] X_HI = 11'(SCREEN_W - SPRITE_W - MARGIN);
  localparam logic [9:0] X_START = 10'(MIR ? (SCREEN_W - START_X - SPRITE_W) : START_X);
  localparam int unsigned KB_W = $clog2(KB_FRAMES + 1);

  motion_e              fsm;
  logic [3:0]           prev_state;
  logic [KB_W-1:0]      kb_cnt;
  logic [9:0]           x_q;
  logic [9:0]           y_q;
  logic                 kb_q;
  logic                 hit_entry;
  logic signed [10:0]   delta;
  logic signed [10:0]   x_sum;
  logic signed [10:0]   x_sat;

  assign hit_entry = (bus.state == S_Hitstun) && (prev_state != S_Hitstun);

  // Knockback step wins over any walk request; saturate rather than refuse
  always_comb begin
    delta = '0;
    if (fsm == M_KNOCK) begin
      delta = 11'(KB_D);
    end else if (bus.state == S_Forward) begin
      delta = 11'(FWD_D);
    end else if (bus.state == S_Backward) begin
      delta = 11'(BACK_D);
    end
    x_sum = $signed({1'b0, x_q}) + delta;
    if (x_sum < X_LO) begin
      x_sat = X_LO;
    end else if (x_sum > X_HI) begin
      x_sat = X_HI;
    end else begin
      x_sat = x_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= M_HOLD;
      prev_state <= S_IDLE;
      kb_cnt     <= '0;
      x_q        <= X_START;
      y_q        <= 10'(Y_POS);
      kb_q       <= 1'b0;
    end else if (bus.frame_tick) begin
      x_q        <= x_sat[9:0];
      prev_state <= bus.state;
      if (hit_entry) begin
        fsm    <= M_KNOCK;
        kb_cnt <= KB_W'(KB_FRAMES);
        kb_q   <= 1'b1;
      end else begin
        case (fsm)
          M_HOLD:  if (is_walk(bus.state)) fsm <= M_WALK;
          M_WALK:  if (!is_walk(bus.state)) fsm <= M_HOLD;
          M_KNOCK: begin
            kb_cnt <= kb_cnt - 1'b1;
            if (kb_cnt == KB_W'(1)) begin
              fsm  <= M_HOLD;
              kb_q <= 1'b0;
            end
          end
          default: fsm <= M_HOLD;
        endcase
      end
    end
  end

  logic [10:0] sx;
  logic [10:0] sy;
  logic        body_hit;
  logic        bandana_hit;
  logic        hitbox_hit;

  assign sx = {1'b0, x_q};
  assign sy = {1'b0, y_q};

  sprite_rect_hit u_body (
    .clk(clk), .rst(rst), .en(1'b1),
    .px(bus.pixel_x), .py(bus.pixel_y),
    .x0(sx), .x1(sx + 11'(SPRITE_W)),
    .y0(sy), .y1(sy + 11'(SPRITE_H)),
    .hit(body_hit)
  );

  sprite_rect_hit u_bandana (
    .clk(clk), .rst(rst), .en(1'b1),
    .px(bus.pixel_x), .py(bus.pixel_y),
    .x0(sx), .x1(sx + 11'(SPRITE_W)),
    .y0(sy + 11'(BANDANA_TOP)), .y1(sy + 11'(BANDANA_BOT)),
    .hit(bandana_hit)
  );

`ifdef FIGHTER_HITBOX_EN
  logic        hb_en;
  logic [10:0] reach;
  logic [10:0] hb_x0;
  logic [10:0] hb_x1;

  // Mirrored hitbox extends left of the body; its left edge floors at 0
  always_comb begin
    hb_en = (bus.state == S_Attack_active) || (bus.state == S_DirAtk_active);
    reach = (bus.state == S_DirAtk_active) ? 11'(2 * HIT_W) : 11'(HIT_W);
    if (MIR) begin
      hb_x1 = sx;
      hb_x0 = (reach > sx) ? '0 : sx - reach;
    end else begin
      hb_x0 = sx + 11'(SPRITE_W);
      hb_x1 = hb_x0 + reach;
    end
  end

  sprite_rect_hit u_hitbox (
    .clk(clk), .rst(rst), .en(hb_en),
    .px(bus.pixel_x), .py(bus.pixel_y),
    .x0(hb_x0), .x1(hb_x1),
    .y0(sy + 11'(HITBOX_TOP)), .y1(sy + 11'(HITBOX_BOT)),
    .hit(hitbox_hit)
  );
`else
  assign hitbox_hit = 1'b0;
`endif

  assign bus.sprite_x   = x_q;
  assign bus.sprite_y   = y_q;
  assign bus.knockback  = kb_q;
  assign bus.in_body    = body_hit;
  assign bus.in_bandana = bandana_hit;
  assign bus.in_hitbox  = hitbox_hit;

endmodule

// File: doc/fighter_sprite_motion.md
# fighter_sprite_motion

Parametrised per-fighter motion and overlay engine: tracks one fighter's on-screen position from its 4-bit action state, steps once per video frame, applies hitstun knockback, clamps to the screen, and produces registered per-pixel region flags (body, bandana, attack hitbox) for the top-level colour mux. One instance per player sits between the player FSM and the VGA pixel path.

## Interface
- `IS_MIRRORED`, 0: 1 = player 2 (starts right, faces left, forward = −x)
- `SCREEN_W`, 640: visible width in pixels
- `SPRITE_W`, 64: body width; `SPRITE_H`, 128: body height
- `START_X`, 100: start distance from the player's own screen edge; `Y_POS`, 100: fixed top row
- `MARGIN`, 2: minimum gap to either screen edge
- `FWD_STEP`, 3; `BACK_STEP`, 2; `KB_STEP`, 4: pixels per frame
- `KB_FRAMES`, 8: knockback duration in frames
- `HIT_W`, 40: attack hitbox reach; doubled for directional attack
- `clk` in 1: pixel/system clock
- `rst` in 1: synchronous, active-high reset
- `frame_tick` in 1: one-cycle pulse per frame (start of vblank)
- `state` in 4: player action state (shared encoding)
- `pixel_x`, `pixel_y` in 10: current scan coordinate
- `sprite_x`, `sprite_y` out 10: top-left of body
- `in_body`, `in_bandana`, `in_hitbox` out 1: registered region flags for the previous cycle's pixel
- `knockback` out 1: high while knockback is active

## Operation
- Reset: `sprite_x` = `IS_MIRRORED` ? `SCREEN_W−START_X−SPRITE_W` (476) : `START_X` (100); `sprite_y` = `Y_POS`; all flags 0; FSM = M_HOLD; knockback counter = 0.
- Motion FSM, evaluated only on `frame_tick`:
  - M_HOLD → M_WALK when `state` ∈ {Forward, Backward}.
  - Any FSM state → M_KNOCK when `state` == Hitstun and the previous ticked state ≠ Hitstun. Counter loads `KB_FRAMES`.
  - M_WALK → M_HOLD when `state` is not a walk state.
  - M_KNOCK → M_HOLD when the counter reaches 0.
- Steps per tick:
  - M_WALK applies ±`FWD_STEP` or ±`BACK_STEP`, with direction set by `IS_MIRRORED`.
  - M_KNOCK applies `KB_STEP` backward and decrements the counter.
- Knockback has priority. It continues even if `state` leaves Hitstun.
- A fresh Hitstun entry during knockback reloads the counter.
- Arithmetic: 11-bit signed intermediate. The result saturates to [`MARGIN`, `SCREEN_W−SPRITE_W−MARGIN`] = [2, 574]. It does not refuse the step.
- Region flags (rectangles are half-open):
  - Body: [x, x+SPRITE_W) × [y, y+SPRITE_H).
  - Bandana: rows [y+10, y+20) within the body width.
  - Hitbox, only in Attack_active (reach `HIT_W`) or DirAtk_active (reach 2·`HIT_W`), rows [y+32, y+48):
    - Unmirrored: x range [x+SPRITE_W, x+SPRITE_W+reach).
    - Mirrored: x range [x−reach, x), with the left edge floored at 0.

## Timing
- Position and `knockback` update on the clock edge where `frame_tick` = 1. They are stable for the rest of the frame.
- Region flags have 1-cycle latency from `pixel_x`/`pixel_y` and use the current `sprite_x`/`sprite_y`.
- `rst` overrides `frame_tick` in the same cycle. Reset during knockback clears it immediately.
- `state` is only sampled on ticks. Changes between ticks are invisible to motion but visible to `in_hitbox` on the next cycle.

## Configuration
- `FIGHTER_HITBOX_EN` defined: `in_hitbox` is computed as above.
- `FIGHTER_HITBOX_EN` undefined: `in_hitbox` is tied to 0, and the hitbox comparator and `HIT_W` logic are removed. All other behaviour is identical.

## Structure
- Shared package `fighter_pkg`:
  - State encodings S_IDLE=0 … S_Blockstun=10.
  - Screen constants (640×480).
  - Motion FSM enum {M_HOLD, M_WALK, M_KNOCK}.
- Sub-module `sprite_rect_hit`: registered half-open rectangle compare with 11-bit bounds. Instantiated for body, bandana and hitbox.

## Test plan
- Reset, `IS_MIRRORED`=0, hold Forward for 5 ticks → `sprite_x` 100→115; no movement between ticks.
- `IS_MIRRORED`=1, Backward from 570, 3 ticks → 572, 574, 574 (saturates, no wrap).
- Hitstun entry at x=300, unmirrored → 8 ticks of −4 → 268, `knockback` drops after tick 8. Re-enter Hitstun at tick 4 → counter reloads, final x=252.
- Attack_active at x=200, unmirrored, pixel (270,140) → `in_hitbox`=1 one cycle later. Pixel (305,140) → 0. DirAtk_active at the same pixel (305,140) → 1.
- Mirrored hitbox at x=20, DirAtk_active → flag at pixel (0,135), none beyond x=19.
- Assert `rst` coincident with a tick during knockback → start position restored, `knockback`=0, flags 0 next cycle.
